// File: rtl/result_ascii_formatter.sv
// rtl/result_ascii_formatter.sv - binary result word to decimal ASCII byte stream (double-dabble)
module result_ascii_formatter #(
    parameter int EMIT_CRLF  = 1,
    parameter int NUM_DIGITS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy
);

    localparam int BCD_W = NUM_DIGITS * 4;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        SCAN,
        EMIT_DIGIT,
        EMIT_CR,
        EMIT_LF
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [5:0]         iter_q, iter_d;
    logic [3:0]         digit_idx_q, digit_idx_d;
    logic [3:0]         msd_idx;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;

    function automatic logic [3:0] nibble(input logic [BCD_W-1:0] v, input logic [3:0] idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // Double-dabble pre-add: nibbles >= 5 get +3 so the following shift carries correctly.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Highest nonzero digit; stays 0 for an all-zero value so "0" is still printed.
    always_comb begin
        msd_idx = 4'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) begin
                msd_idx = i[3:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            iter_q      <= '0;
            digit_idx_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            iter_q      <= iter_d;
            digit_idx_q <= digit_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // out_valid/out_data are registered from the next state so out_ready never reaches out_valid combinationally.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        iter_d      = iter_q;
        digit_idx_d = digit_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = in_data;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[31]};
                bin_d  = {bin_q[30:0], 1'b0};
                iter_d = iter_q + 6'd1;
                if (iter_q == 6'd31) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                digit_idx_d = msd_idx;
                out_valid_d = 1'b1;
                out_data_d  = ascii_digit(nibble(bcd_q, msd_idx));
                state_d     = EMIT_DIGIT;
            end
            EMIT_DIGIT: begin
                if (out_ready) begin
                    if (digit_idx_q == 4'd0) begin
                        if (EMIT_CRLF != 0) begin
                            out_data_d = 8'h0D;
                            state_d    = EMIT_CR;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = IDLE;
                        end
                    end else begin
                        digit_idx_d = digit_idx_q - 4'd1;
                        out_data_d  = ascii_digit(nibble(bcd_q, digit_idx_q - 4'd1));
                    end
                end
            end
            EMIT_CR: begin
                if (out_ready) begin
                    out_data_d = 8'h0A;
                    state_d    = EMIT_LF;
                end
            end
            EMIT_LF: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
